// File: rtl/core_task_receiver_if.sv
// Dispatcher-to-core task interface: select/task word in, status and thermal feedback out.
interface core_task_receiver_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    core_select;
    logic [15:0]   task_data;
    logic [7:0]    temp_core;
    logic          busy;
    logic          task_done;
    logic [11:0]   done_tag;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output core_select, task_data,
        input  temp_core, busy, task_done, done_tag, fifo_count, overflow
    );

    modport slave (
        input  core_select, task_data,
        output temp_core, busy, task_done, done_tag, fifo_count, overflow
    );
endinterface

// File: rtl/core_task_receiver.sv
// Core-side task endpoint: captures tasks on the rising edge of this core's select,
// buffers them, runs each for dur+1 cycles, pulses task_done, and models temperature.
module core_task_receiver #(
    parameter logic [1:0]  CORE_ID      = 2'd0,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  TEMP_AMBIENT = 8'd25,
    parameter logic [7:0]  TEMP_MAX     = 8'd120,
    parameter int unsigned HEAT_DIV     = 4,
    parameter int unsigned COOL_DIV     = 8
) (
    input logic                clk,
    input logic                rst,
    core_task_receiver_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Capture edge detection
    logic match;
    logic match_q;
    logic push_req;

    // Task FIFO
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          push;
    logic          pop;
    logic [15:0]   head;
    logic          overflow_q;

    // Execution FSM
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [11:0] tag_q;
    logic [11:0] tag_d;

    // Thermal model
    logic       in_run;
    logic       run_q;
    logic [7:0] div_q;
    logic [7:0] div_d;
    logic [7:0] div_base;
    logic [7:0] div_lim;
    logic [7:0] temp_q;
    logic [7:0] temp_d;

    assign match    = (bus.core_select == CORE_ID);
    assign push_req = match & ~match_q;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push     = push_req & ~full;
    assign pop      = (state_q == ST_IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    // Next-state for the occupancy counter
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Edge detector, FIFO pointers/count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            match_q <= match;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.task_data;
        end
    end

    // FSM next-state: pop into RUN, count down dur+1 cycles, one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cnt_d   = head[15:12];
                    tag_d   = head[11:0];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            tag_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    assign in_run = (state_q == ST_RUN);

    // Thermal next-state; the divider restarts from zero on the first cycle of a new phase
    always_comb begin
        div_base = (in_run != run_q) ? 8'd0 : div_q;
        div_lim  = in_run ? 8'(HEAT_DIV - 1) : 8'(COOL_DIV - 1);
        temp_d   = temp_q;
        div_d    = div_base + 8'd1;
        if (div_base >= div_lim) begin
            div_d = 8'd0;
            if (in_run) begin
                if (temp_q < TEMP_MAX) begin
                    temp_d = temp_q + 8'd1;
                end
            end else begin
                if (temp_q > TEMP_AMBIENT) begin
                    temp_d = temp_q - 8'd1;
                end
            end
        end
    end

    // Thermal state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            div_q  <= 8'd0;
            temp_q <= TEMP_AMBIENT;
        end else begin
            run_q  <= in_run;
            div_q  <= div_d;
            temp_q <= temp_d;
        end
    end

    assign bus.temp_core  = temp_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.task_done  = (state_q == ST_DONE);
    assign bus.done_tag   = (state_q == ST_DONE) ? tag_q : 12'd0;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_core_task_receiver.sv
// Directed bench for core_task_receiver (CORE_ID=0, default parameters).
module tb_core_task_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [11:0] last_tag = 12'd0;
    int max_t = 0;
    int min_t = 255;

    always #5 clk = ~clk;

    core_task_receiver_if #(.FIFO_DEPTH(4)) bus ();

    core_task_receiver #(
        .CORE_ID     (2'd0),
        .FIFO_DEPTH  (4),
        .TEMP_AMBIENT(8'd25),
        .TEMP_MAX    (8'd120),
        .HEAT_DIV    (4),
        .COOL_DIV    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Count completions as they are seen at the clock edge
    always @(posedge clk) begin
        if (bus.task_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_tag = bus.done_tag;
        end
    end

    // Track temperature extremes away from the edge
    always @(negedge clk) begin
        if (!rst && !$isunknown(bus.temp_core)) begin
            if (int'(bus.temp_core) > max_t) max_t = int'(bus.temp_core);
            if (int'(bus.temp_core) < min_t) min_t = int'(bus.temp_core);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] d);
        bus.core_select = 2'b00;
        bus.task_data   = d;
        step(1);
        bus.core_select = 2'b11;
        step(1);
    endtask

    task automatic do_reset();
        bus.core_select = 2'b11;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        done_cnt = 0;
    endtask

    task automatic test_reset();
        bus.core_select = 2'b11;
        bus.task_data   = 16'h0000;
        rst = 1'b1;
        step(2);
        n_tests++; if (bus.temp_core !== 8'd25) begin n_fail++;
            $display("FAIL reset_temp: got %0d expected 25", bus.temp_core); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        n_tests++; if (bus.overflow !== 1'b0 || bus.task_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_flags: got ovf=%b done=%b expected 0/0",
                     bus.overflow, bus.task_done); end
        rst = 1'b0;
        done_cnt = 0;
        step(1);
    endtask

    task automatic test_single();
        bus.core_select = 2'b00;
        bus.task_data   = 16'h3ABC;
        step(1);                             // cycle t+1
        bus.core_select = 2'b11;
        n_tests++; if (bus.fifo_count !== 3'd1 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL single_t1: got cnt=%0d busy=%b expected 1/0",
                     bus.fifo_count, bus.busy); end
        step(1);                             // t+2
        n_tests++; if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL single_t2: got busy=%b cnt=%0d expected 1/0",
                     bus.busy, bus.fifo_count); end
        step(3);                             // t+5
        n_tests++; if (bus.task_done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
            $display("FAIL single_t5: got done=%b busy=%b expected 0/1",
                     bus.task_done, bus.busy); end
        step(1);                             // t+6
        n_tests++; if (bus.task_done !== 1'b1 || bus.done_tag !== 12'hABC) begin n_fail++;
            $display("FAIL single_t6: got done=%b tag=%h expected 1/abc",
                     bus.task_done, bus.done_tag); end
        step(1);                             // t+7
        n_tests++; if (bus.task_done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL single_t7: got done=%b busy=%b expected 0/0",
                     bus.task_done, bus.busy); end
        n_tests++; if (done_cnt !== 1) begin n_fail++;
            $display("FAIL single_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_addressing();
        done_cnt = 0;
        bus.core_select = 2'b00;
        bus.task_data   = 16'h0123;
        step(4);                             // select held, t+4
        n_tests++; if (bus.fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL held_select_count: got %0d expected 0", bus.fifo_count); end
        step(1);
        bus.core_select = 2'b11;
        step(10);
        n_tests++; if (done_cnt !== 1 || last_tag !== 12'h123) begin n_fail++;
            $display("FAIL held_select_caps: got n=%0d tag=%h expected 1/123",
                     done_cnt, last_tag); end
        for (int i = 0; i < 3; i++) begin
            bus.core_select = 2'b01;
            bus.task_data   = 16'h0777;
            step(1);
            bus.core_select = 2'b11;
            step(1);
        end
        n_tests++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL other_core: got cnt=%0d busy=%b expected 0/0",
                     bus.fifo_count, bus.busy); end
        // 00 -> 01 -> 00 is two separate edges
        done_cnt = 0;
        bus.core_select = 2'b00; bus.task_data = 16'h0011; step(1);
        bus.core_select = 2'b01; step(1);
        bus.core_select = 2'b00; bus.task_data = 16'h0022; step(1);
        bus.core_select = 2'b11; step(15);
        n_tests++; if (done_cnt !== 2 || last_tag !== 12'h022) begin n_fail++;
            $display("FAIL reselect: got n=%0d tag=%h expected 2/022", done_cnt, last_tag); end
    endtask

    task automatic test_back_to_back();
        bus.core_select = 2'b00; bus.task_data = 16'h0AAA; step(1);  // t+1
        bus.core_select = 2'b11; step(1);                            // t+2
        bus.core_select = 2'b00; bus.task_data = 16'h0BBB; step(1);  // t+3
        bus.core_select = 2'b11;
        n_tests++; if (bus.task_done !== 1'b1 || bus.done_tag !== 12'hAAA) begin n_fail++;
            $display("FAIL b2b_first: got done=%b tag=%h expected 1/aaa",
                     bus.task_done, bus.done_tag); end
        step(1);                                                     // t+4
        n_tests++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd1) begin n_fail++;
            $display("FAIL b2b_gap: got busy=%b cnt=%0d expected 0/1",
                     bus.busy, bus.fifo_count); end
        step(2);                                                     // t+6
        n_tests++; if (bus.task_done !== 1'b1 || bus.done_tag !== 12'hBBB) begin n_fail++;
            $display("FAIL b2b_second: got done=%b tag=%h expected 1/bbb",
                     bus.task_done, bus.done_tag); end
        step(2);
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 6; k++) begin
            pulse({4'hF, 12'(k)});
        end                                  // now cycle 12
        n_tests++; if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b1) begin n_fail++;
            $display("FAIL ovf_fill: got cnt=%0d ovf=%b expected 4/1",
                     bus.fifo_count, bus.overflow); end
        step(7);                             // cycle 19: IDLE, popping with FIFO full
        n_tests++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd4) begin n_fail++;
            $display("FAIL ovf_idle: got busy=%b cnt=%0d expected 0/4",
                     bus.busy, bus.fifo_count); end
        bus.core_select = 2'b00; bus.task_data = 16'hF007; step(1);
        bus.core_select = 2'b11;
        n_tests++; if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1) begin n_fail++;
            $display("FAIL ovf_push_pop_full: got cnt=%0d busy=%b expected 3/1",
                     bus.fifo_count, bus.busy); end
        step(30);
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        do_reset();
        n_tests++; if (bus.overflow !== 1'b0 || bus.fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL ovf_clear: got ovf=%b cnt=%0d expected 0/0",
                     bus.overflow, bus.fifo_count); end
    endtask

    task automatic test_thermal();
        int pushed;
        int budget;
        do_reset();
        pulse(16'hF111);                     // now t+2
        step(15);                            // t+17
        n_tests++; if (bus.temp_core !== 8'd28) begin n_fail++;
            $display("FAIL heat_t17: got %0d expected 28", bus.temp_core); end
        step(1);                             // t+18
        n_tests++; if (bus.temp_core !== 8'd29 || bus.task_done !== 1'b1) begin n_fail++;
            $display("FAIL heat_done: got temp=%0d done=%b expected 29/1",
                     bus.temp_core, bus.task_done); end
        step(31);                            // t+49
        n_tests++; if (bus.temp_core !== 8'd26) begin n_fail++;
            $display("FAIL cool_t49: got %0d expected 26", bus.temp_core); end
        step(1);                             // t+50
        n_tests++; if (bus.temp_core !== 8'd25) begin n_fail++;
            $display("FAIL cool_t50: got %0d expected 25", bus.temp_core); end
        step(40);
        n_tests++; if (bus.temp_core !== 8'd25) begin n_fail++;
            $display("FAIL cool_floor: got %0d expected 25", bus.temp_core); end
        // Keep the core saturated with dur=15 tasks until it hits the ceiling
        max_t = 0; min_t = 255;
        pushed = 0; budget = 0;
        while (pushed < 30 && budget < 3000) begin
            if (bus.fifo_count < 3'd3) begin
                pulse(16'hF0EE);
                pushed++;
                budget += 2;
            end else begin
                step(1);
                budget++;
            end
        end
        n_tests++; if (pushed != 30) begin n_fail++;
            $display("FAIL sat_feed: got %0d tasks pushed expected 30", pushed); end
        n_tests++; if (bus.temp_core !== 8'd120) begin n_fail++;
            $display("FAIL sat_temp: got %0d expected 120", bus.temp_core); end
        n_tests++; if (max_t != 120 || min_t < 25) begin n_fail++;
            $display("FAIL sat_range: got max=%0d min=%0d expected 120/>=25", max_t, min_t); end
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        pulse(16'hF101);
        pulse(16'hF102);
        pulse(16'hF103);                     // cycle 6: first task running
        n_tests++; if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd2) begin n_fail++;
            $display("FAIL midrun_pre: got busy=%b cnt=%0d expected 1/2",
                     bus.busy, bus.fifo_count); end
        n_tests++; if (bus.temp_core !== 8'd26) begin n_fail++;
            $display("FAIL midrun_pre_temp: got %0d expected 26", bus.temp_core); end
        done_cnt = 0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL midrun_post: got busy=%b cnt=%0d expected 0/0",
                     bus.busy, bus.fifo_count); end
        n_tests++; if (bus.temp_core !== 8'd25 || bus.task_done !== 1'b0) begin n_fail++;
            $display("FAIL midrun_post_temp: got temp=%0d done=%b expected 25/0",
                     bus.temp_core, bus.task_done); end
        step(40);
        n_tests++; if (done_cnt !== 0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL midrun_no_done: got n=%0d busy=%b expected 0/0",
                     done_cnt, bus.busy); end
    endtask

    initial begin
        bus.core_select = 2'b11;
        bus.task_data   = 16'h0000;
        #1;
        test_reset();
        test_single();
        test_addressing();
        test_back_to_back();
        test_overflow();
        test_thermal();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
